// File: rtl/bwt_pkg.sv
// Shared types and constants for the inverse Burrows-Wheeler decoder.
package bwt_pkg;

  localparam int CHAR_W    = 8;
  localparam int DEFAULT_N = 8;

  typedef logic [CHAR_W-1:0] char_t;

  // Controller states, kept as plain constants for legacy tool flows.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t BUILD = 2'd1;
  localparam state_t WALK  = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage

// File: rtl/bwt_lf_unit.sv
// Combinational LF-mapping entry: LF[idx] = C(L[idx]) + occ(idx), where C is the
// first row of the character in F and occ counts earlier copies of it in L.
module bwt_lf_unit
  import bwt_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  char_t            l   [0:N-1],
  input  char_t            f   [0:N-1],
  input  logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] lf
);

  char_t            c;
  logic             found;
  logic [IDX_W-1:0] first_pos;
  logic [IDX_W-1:0] occ;

  always_comb begin
    c         = l[idx];
    found     = 1'b0;
    first_pos = '0;
    occ       = '0;
    for (int j = 0; j < N; j++) begin
      if (!found && f[j] == c) begin
        first_pos = IDX_W'(j);
        found     = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (j < int'(idx) && l[j] == c) occ = occ + IDX_W'(1);
    end
    lf = first_pos + occ;
  end

endmodule

// File: rtl/bwt_inverse_decoder.sv
// Inverse BWT: captures L, F and the primary row, builds the LF table one entry per
// cycle, then walks it backwards to rebuild the original string.
module bwt_inverse_decoder
  import bwt_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CHAR_W-1:0]   data_last   [0:N-1],
  input  logic [CHAR_W-1:0]   data_sorted [0:N-1],
  input  logic [IDX_W-1:0]    primary_idx,
  output logic [CHAR_W-1:0]   data_out    [0:N-1],
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  state_t           state;
  char_t            l_reg  [0:N-1];
  char_t            f_reg  [0:N-1];
  char_t            t_reg  [0:N-1];
  logic [IDX_W-1:0] lf_reg [0:N-1];
  logic [IDX_W-1:0] i_cnt;
  logic [IDX_W-1:0] k_cnt;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] lf_val;
  logic             bad_idx;

  bwt_lf_unit #(.N(N), .IDX_W(IDX_W)) u_lf (
    .l   (l_reg),
    .f   (f_reg),
    .idx (i_cnt),
    .lf  (lf_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      i_cnt   <= '0;
      k_cnt   <= '0;
      r_idx   <= '0;
      bad_idx <= 1'b0;
      for (int j = 0; j < N; j++) begin
        l_reg[j]    <= '0;
        f_reg[j]    <= '0;
        t_reg[j]    <= '0;
        lf_reg[j]   <= '0;
        data_out[j] <= '0;
      end
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            l_reg   <= data_last;
            f_reg   <= data_sorted;
            r_idx   <= primary_idx;
            i_cnt   <= '0;
            busy    <= 1'b1;
            bad_idx <= (int'(primary_idx) >= N);
            state   <= (int'(primary_idx) >= N) ? DONE : BUILD;
          end
        end
        BUILD: begin
          lf_reg[i_cnt] <= lf_val;
          i_cnt         <= i_cnt + IDX_W'(1);
          if (i_cnt == LAST) begin
            k_cnt <= LAST;
            state <= WALK;
          end
        end
        WALK: begin
          // The walk visits the string back to front, so fill T from the end.
          t_reg[k_cnt] <= l_reg[r_idx];
          r_idx        <= lf_reg[r_idx];
          k_cnt        <= k_cnt - IDX_W'(1);
          if (k_cnt == '0) state <= DONE;
        end
        DONE: begin
          for (int j = 0; j < N; j++) data_out[j] <= bad_idx ? '0 : t_reg[j];
          done  <= 1'b1;
          err   <= bad_idx;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bwt_inverse_decoder.sv
// Self-checking bench for bwt_inverse_decoder: table-driven vectors on an N=8 instance
// with a result scoreboard, plus an N=6 instance and hand-written corner sequences.
module tb_bwt_inverse_decoder;

  typedef struct {
    logic [63:0] l;
    logic [63:0] f;
    logic [3:0]  p;
    logic [63:0] exp;
    logic        err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, start6;
  logic [7:0] l8 [0:7], f8 [0:7], out8 [0:7];
  logic [7:0] l6 [0:5], f6 [0:5], out6 [0:5];
  logic [3:0] p8;
  logic [2:0] p6;
  logic       busy8, done8, err8, busy6, done6, err6;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q8[$];
  vec_t vecs [0:6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bwt_inverse_decoder #(.N(8), .IDX_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .data_last(l8), .data_sorted(f8),
    .primary_idx(p8), .data_out(out8), .busy(busy8), .done(done8), .err(err8)
  );

  bwt_inverse_decoder #(.N(6)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start6), .data_last(l6), .data_sorted(f6),
    .primary_idx(p6), .data_out(out6), .busy(busy6), .done(done6), .err(err6)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] s2b(input string s);
    logic [63:0] r = '0;
    for (int j = 0; j < s.len(); j++) r[63-8*j -: 8] = s[j];
    return r;
  endfunction

  function automatic logic [63:0] pack8();
    logic [63:0] r = '0;
    for (int j = 0; j < 8; j++) r[63-8*j -: 8] = out8[j];
    return r;
  endfunction

  function automatic logic [63:0] pack6();
    logic [63:0] r = '0;
    for (int j = 0; j < 6; j++) r[63-8*j -: 8] = out6[j];
    return r;
  endfunction

  function automatic vec_t mk(input string l, input string f, input int p, input string e, input logic er);
    vec_t v;
    v.l = s2b(l); v.f = s2b(f); v.p = 4'(p); v.exp = s2b(e); v.err = er;
    return v;
  endfunction

  // Forward BWT reference: sort all rotations of a non-periodic random string.
  task automatic makeRandomVec(output vec_t v);
    logic [63:0] s;
    logic [63:0] rot [0:7];
    int          ord [0:7];
    int          tmp;
    bit          periodic;
    do begin
      for (int j = 0; j < 8; j++) s[63-8*j -: 8] = 8'(8'h61 + $urandom_range(0, 2));
      for (int k = 0; k < 8; k++) begin
        rot[k] = (k == 0) ? s : ((s << (8*k)) | (s >> (64 - 8*k)));
        ord[k] = k;
      end
      periodic = 1'b0;
      for (int k = 1; k < 8; k++) if (rot[k] == s) periodic = 1'b1;
    end while (periodic);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 7 - a; b++)
        if (rot[ord[b]] > rot[ord[b+1]]) begin
          tmp = ord[b]; ord[b] = ord[b+1]; ord[b+1] = tmp;
        end
    v.l = '0; v.f = '0; v.p = '0;
    for (int i = 0; i < 8; i++) begin
      v.l[63-8*i -: 8] = rot[ord[i]][7:0];
      v.f[63-8*i -: 8] = rot[ord[i]][63:56];
      if (ord[i] == 0) v.p = 4'(i);
    end
    v.exp = s;
    v.err = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t e;
    for (int j = 0; j < 8; j++) begin
      l8[j] = v.l[63-8*j -: 8];
      f8[j] = v.f[63-8*j -: 8];
    end
    p8 = v.p;
    @(negedge clk);
    start8 = 1'b1;
    e.data = v.exp;
    e.err  = v.err;
    e.due  = cyc + 1 + (v.err ? 1 : 17);
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0;
    checkOutput("busy_after_start8", 64'(busy8), 64'd1);
  endtask

  task automatic waitDone8(input int budget);
    int n = 0;
    while (q8.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pending_results8", 64'(q8.size()), 64'd0);
    q8.delete();
  endtask

  // Scoreboard side: every done pulse must match the oldest outstanding request.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected_done8", 64'd1, 64'd0);
      end else begin
        e = q8.pop_front();
        checkOutput("data_out8", pack8(), e.data);
        checkOutput("err8", 64'(err8), 64'(e.err));
        checkOutput("latency8", 64'(cyc), 64'(e.due));
        checkOutput("busy_at_done8", 64'(busy8), 64'd1);
      end
    end
  end

  initial begin
    int s;
    int seen;
    rst_n = 1'b0; start8 = 1'b0; start6 = 1'b0; p8 = '0; p6 = '0;
    for (int j = 0; j < 8; j++) begin l8[j] = '0; f8[j] = '0; end
    for (int j = 0; j < 6; j++) begin l6[j] = '0; f6[j] = '0; end

    vecs[0] = mk("habcdefg", "abcdefgh", 0, "abcdefgh", 1'b0);
    vecs[1] = mk("aaaaaaaa", "aaaaaaaa", 5, "aaaaaaaa", 1'b0);
    vecs[2] = mk("habcdefg", "abcdefgh", 9, "", 1'b1);
    for (int i = 3; i < 7; i++) makeRandomVec(vecs[i]);

    repeat (2) @(negedge clk);
    checkOutput("reset_busy8", 64'(busy8), 64'd0);
    checkOutput("reset_done8", 64'(done8), 64'd0);
    checkOutput("reset_err8", 64'(err8), 64'd0);
    checkOutput("reset_data8", pack8(), 64'd0);
    checkOutput("reset_busy6", 64'(busy6), 64'd0);
    checkOutput("reset_data6", pack6(), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // N=6 banana run, done expected 13 cycles after the start edge.
    for (int j = 0; j < 6; j++) begin
      l6[j] = s2b("nnbaaa")[63-8*j -: 8];
      f6[j] = s2b("aaabnn")[63-8*j -: 8];
    end
    p6 = 3'd3;
    start6 = 1'b1;
    s = cyc + 1;
    @(negedge clk);
    start6 = 1'b0;
    seen = -1;
    for (int n = 0; n < 30 && seen < 0; n++) begin
      @(negedge clk);
      if (done6 === 1'b1) seen = cyc;
    end
    checkOutput("latency6", 64'(seen), 64'(s + 13));
    checkOutput("data_out6", pack6(), s2b("banana"));
    checkOutput("err6", 64'(err6), 64'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      waitDone8(40);
    end

    // Second start and input changes during WALK must not disturb the run.
    applyStimulus(vecs[0]);
    repeat (10) @(negedge clk);
    for (int j = 0; j < 8; j++) l8[j] = 8'h7a;
    p8 = 4'd2;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitDone8(30);
    repeat (20) @(negedge clk);
    checkOutput("idle_after_walk_start8", 64'(busy8), 64'd0);

    // Start sampled in the DONE cycle is ignored.
    applyStimulus(vecs[1]);
    repeat (16) @(negedge clk);
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    checkOutput("done_cycle_start_ignored8", 64'(busy8), 64'd0);
    checkOutput("pending_after_done8", 64'(q8.size()), 64'd0);
    repeat (20) @(negedge clk);
    checkOutput("data_hold8", pack8(), s2b("aaaaaaaa"));

    // Reset pulse mid-BUILD: no done pulse, outputs cleared, then a clean rerun.
    applyStimulus(vecs[0]);
    @(negedge clk);
    rst_n = 1'b0;
    q8.delete();
    #1;
    checkOutput("midreset_busy8", 64'(busy8), 64'd0);
    checkOutput("midreset_data8", pack8(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    checkOutput("after_reset_busy8", 64'(busy8), 64'd0);
    applyStimulus(vecs[0]);
    waitDone8(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
